// File: rtl/gray_step_counter_pkg.sv
// Shared types and Gray-code helpers for the Gray step counter and its downstream consumers.
// The helpers work on a wide vector, so callers zero-extend their operand and truncate the result.
package gray_step_counter_pkg;

   localparam int GRAY_MAX_W = 64;

   // Operation chosen for the current cycle once reset has been ruled out.
   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_LOAD  = 2'd1,
      OP_COUNT = 2'd2
   } op_e;

   // Range event raised by the count arithmetic.
   typedef enum logic [1:0] {
      EV_NONE      = 2'd0,
      EV_OVERFLOW  = 2'd1,
      EV_UNDERFLOW = 2'd2
   } range_ev_e;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Prefix XOR from the MSB down. The zero-extended upper bits leave the result unaffected.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
      logic [GRAY_MAX_W-1:0] b;
      b = g;
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_enc.sv
// Purely combinational binary-to-Gray encoder.
module gray_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] bin_i,
   output logic [N-1:0] gray_o
);

   assign gray_o[N-1] = bin_i[N-1];

   generate
      for (genvar gi = 0; gi < N - 1; gi++) begin : g_bit
         assign gray_o[gi] = bin_i[gi+1] ^ bin_i[gi];
      end
   endgenerate

endmodule

// File: rtl/gray_step_counter.sv
// N-bit binary accumulator advanced by a signed step, with wrap or saturate handling.
// It drives registered binary, Gray, overflow and zero outputs.
module gray_step_counter
   import gray_step_counter_pkg::*;
#(
   parameter int N           = 8,
   parameter int STEP_W      = 3,
   parameter int SATURATE    = 0,
   parameter int LEGACY_ZERO = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              load,
   input  logic [N-1:0]      load_val,
   input  logic [STEP_W-1:0] step,
   output logic [N-1:0]      gray_out,
   output logic [N-1:0]      bin_out,
   output logic              ovf,
   output logic              zero
);

   // Two guard bits: the top bit flags underflow, and the next one flags overflow.
   localparam int            SUM_W   = N + 2;
   localparam logic [N-1:0]  MAX_VAL = {N{1'b1}};

   logic [N-1:0]            bin_q, bin_d;
   logic [N-1:0]            gray_q, gray_d;
   logic                    ovf_q, ovf_d;
   logic                    zero_q, zero_d;

   op_e                     op;
   range_ev_e               range_ev;
   logic signed [SUM_W-1:0] eff_step;
   logic signed [SUM_W-1:0] sum;
   logic [N-1:0]            count_val;

   always_comb begin
      op = OP_HOLD;
      if (load) begin
         op = OP_LOAD;
      end else if (en) begin
         op = OP_COUNT;
      end
   end

   always_comb begin
      eff_step = {{(SUM_W - STEP_W){step[STEP_W-1]}}, step};
      if ((LEGACY_ZERO != 0) && (step == '0)) begin
         eff_step = '1;
      end
      sum = $signed({2'b00, bin_q}) + eff_step;

      range_ev = EV_NONE;
      if (sum[SUM_W-1]) begin
         range_ev = EV_UNDERFLOW;
      end else if (sum[N]) begin
         range_ev = EV_OVERFLOW;
      end

      count_val = sum[N-1:0];
      if (SATURATE != 0) begin
         if (range_ev == EV_OVERFLOW) begin
            count_val = MAX_VAL;
         end else if (range_ev == EV_UNDERFLOW) begin
            count_val = '0;
         end
      end
   end

   always_comb begin
      bin_d = bin_q;
      ovf_d = 1'b0;
      unique case (op)
         OP_LOAD: begin
            bin_d = load_val;
         end
         OP_COUNT: begin
            bin_d = count_val;
            ovf_d = (range_ev != EV_NONE);
         end
         default: begin
            bin_d = bin_q;
         end
      endcase
      zero_d = (bin_d == '0);
   end

   // Gray is encoded from the next binary value, so both registers always agree.
   gray_enc #(
      .N(N)
   ) u_gray_enc (
      .bin_i  (bin_d),
      .gray_o (gray_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         bin_q  <= '0;
         gray_q <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b1;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

   assign bin_out  = bin_q;
   assign gray_out = gray_q;
   assign ovf      = ovf_q;
   assign zero     = zero_q;

endmodule

// File: tb/tb_gray_step_counter.sv
// Scoreboard bench for gray_step_counter with three variants: wrap/legacy, saturate/legacy and wrap/hold-on-zero.
module tb_gray_step_counter;

   localparam int N  = 4;
   localparam int SW = 3;

   localparam int I_WRAP = 0;
   localparam int I_SAT  = 1;
   localparam int I_NZ   = 2;

   logic          clk = 1'b0;
   logic          reset, en, load;
   logic [N-1:0]  load_val;
   logic [SW-1:0] step;

   logic [N-1:0]  w_gray, w_bin, s_gray, s_bin, h_gray, h_bin;
   logic          w_ovf, w_zero, s_ovf, s_zero, h_ovf, h_zero;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [N-1:0] bin;
      logic [N-1:0] gray;
      logic         ovf;
      logic         zero;
   } obs_t;

   typedef struct {
      int    inst;
      obs_t  exp;
      string tag;
   } sb_t;

   sb_t sb_q[$];

   always #5 clk = ~clk;

   gray_step_counter #(.N(N), .STEP_W(SW), .SATURATE(0), .LEGACY_ZERO(1)) u_wrap (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .step(step),
      .gray_out(w_gray), .bin_out(w_bin), .ovf(w_ovf), .zero(w_zero)
   );

   gray_step_counter #(.N(N), .STEP_W(SW), .SATURATE(1), .LEGACY_ZERO(1)) u_sat (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .step(step),
      .gray_out(s_gray), .bin_out(s_bin), .ovf(s_ovf), .zero(s_zero)
   );

   gray_step_counter #(.N(N), .STEP_W(SW), .SATURATE(0), .LEGACY_ZERO(0)) u_nz (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val), .step(step),
      .gray_out(h_gray), .bin_out(h_bin), .ovf(h_ovf), .zero(h_zero)
   );

   function automatic obs_t observe(input int inst);
      case (inst)
         I_WRAP:  return {w_bin, w_gray, w_ovf, w_zero};
         I_SAT:   return {s_bin, s_gray, s_ovf, s_zero};
         default: return {h_bin, h_gray, h_ovf, h_zero};
      endcase
   endfunction

   function automatic logic [N-1:0] gray_of(input logic [N-1:0] b);
      logic [N-1:0] g;
      for (int i = 0; i < N; i++) begin
         g[i] = (i == N - 1) ? b[i] : (b[i] ^ b[i+1]);
      end
      return g;
   endfunction

   task automatic push(input int inst, input logic [N-1:0] b, input logic [N-1:0] g,
                       input logic o, input logic z, input string tag);
      sb_t e;
      e.inst = inst;
      e.exp  = {b, g, o, z};
      e.tag  = tag;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      sb_t  e;
      obs_t o;
      reset = 1'b1; load = 1'b1; load_val = 4'd7; en = 1'b1; step = 3'd0;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 3; i++) push(i, 4'd0, 4'b0000, 1'b0, 1'b1, "reset");
         tick();
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.inst);
            checks++;
            if (o !== e.exp) begin
               errors++;
               $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                        e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
            end else begin
               $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
            end
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_legacy_down();
      sb_t  e;
      obs_t o;
      load = 1'b0; en = 1'b1; step = 3'd0;
      push(I_WRAP, 4'd15, 4'b1000, 1'b1, 1'b0, "legacy_wrap");
      push(I_SAT,  4'd0,  4'b0000, 1'b1, 1'b1, "legacy_clamp");
      push(I_NZ,   4'd0,  4'b0000, 1'b0, 1'b1, "zero_hold");
      tick();
      push(I_WRAP, 4'd14, 4'b1001, 1'b0, 1'b0, "legacy_down");
      push(I_SAT,  4'd0,  4'b0000, 1'b1, 1'b1, "legacy_clamp2");
      push(I_NZ,   4'd0,  4'b0000, 1'b0, 1'b1, "zero_hold2");
      while (sb_q.size() > 0) begin
         if (sb_q[0].tag == "legacy_down") tick();
         e = sb_q.pop_front();
         o = observe(e.inst);
         checks++;
         if (o !== e.exp) begin
            errors++;
            $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                     e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
         end else begin
            $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
         end
      end
   endtask

   task automatic test_wrap();
      sb_t  e;
      obs_t o;
      for (int s = 0; s < 4; s++) begin
         case (s)
            0: begin
               load = 1'b1; load_val = 4'd14; en = 1'b0;
               for (int i = 0; i < 3; i++) push(i, 4'd14, 4'b1001, 1'b0, 1'b0, "load14");
            end
            1: begin
               load = 1'b0; en = 1'b1; step = 3'd3;
               push(I_WRAP, 4'd1,  4'b0001, 1'b1, 1'b0, "wrap_up");
               push(I_SAT,  4'd15, 4'b1000, 1'b1, 1'b0, "clamp_up");
               push(I_NZ,   4'd1,  4'b0001, 1'b1, 1'b0, "wrap_up_nz");
            end
            2: begin
               load = 1'b1; load_val = 4'd2; en = 1'b0;
               push(I_WRAP, 4'd2, 4'b0011, 1'b0, 1'b0, "load2");
            end
            default: begin
               load = 1'b0; en = 1'b1; step = 3'b100;
               push(I_WRAP, 4'd14, 4'b1001, 1'b1, 1'b0, "wrap_down");
               push(I_SAT,  4'd0,  4'b0000, 1'b1, 1'b1, "clamp_down");
            end
         endcase
         tick();
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.inst);
            checks++;
            if (o !== e.exp) begin
               errors++;
               $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                        e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
            end else begin
               $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
            end
         end
      end
   endtask

   task automatic test_saturate();
      sb_t  e;
      obs_t o;
      for (int s = 0; s < 6; s++) begin
         if (s == 0) begin
            load = 1'b1; load_val = 4'd13; en = 1'b0;
            push(I_SAT, 4'd13, 4'b1011, 1'b0, 1'b0, "sat_load13");
         end else if (s <= 3) begin
            load = 1'b0; en = 1'b1; step = 3'd3;
            push(I_SAT, 4'd15, 4'b1000, 1'b1, 1'b0, "sat_high");
            if (s == 1) push(I_WRAP, 4'd0, 4'b0000, 1'b1, 1'b1, "wrap_to_zero");
            if (s == 2) push(I_WRAP, 4'd3, 4'b0010, 1'b0, 1'b0, "wrap_after");
         end else if (s == 4) begin
            load = 1'b1; load_val = 4'd2; en = 1'b0;
            push(I_SAT, 4'd2, 4'b0011, 1'b0, 1'b0, "sat_load2");
         end else begin
            load = 1'b0; en = 1'b1; step = 3'b100;
            push(I_SAT, 4'd0, 4'b0000, 1'b1, 1'b1, "sat_low");
         end
         tick();
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.inst);
            checks++;
            if (o !== e.exp) begin
               errors++;
               $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                        e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
            end else begin
               $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
            end
         end
      end
   endtask

   task automatic test_load_priority();
      sb_t  e;
      obs_t o;
      for (int s = 0; s < 8; s++) begin
         case (s)
            0: begin
               load = 1'b1; load_val = 4'd5; en = 1'b0;
               push(I_WRAP, 4'd5, 4'b0111, 1'b0, 1'b0, "load5");
            end
            1: begin
               load = 1'b1; load_val = 4'd9; en = 1'b1; step = 3'd1;
               push(I_WRAP, 4'd9, 4'b1101, 1'b0, 1'b0, "load_over_en");
            end
            2, 3, 4: begin
               load = 1'b0; en = 1'b0; step = 3'd1;
               push(I_WRAP, 4'd9, 4'b1101, 1'b0, 1'b0, "hold");
            end
            5: begin
               load = 1'b1; load_val = 4'd15; en = 1'b0;
               push(I_WRAP, 4'd15, 4'b1000, 1'b0, 1'b0, "load15");
            end
            6: begin
               load = 1'b0; en = 1'b1; step = 3'd1;
               push(I_WRAP, 4'd0, 4'b0000, 1'b1, 1'b1, "wrap_15_0");
            end
            default: begin
               en = 1'b0;
               push(I_WRAP, 4'd0, 4'b0000, 1'b0, 1'b1, "hold_clears_ovf");
            end
         endcase
         tick();
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.inst);
            checks++;
            if (o !== e.exp) begin
               errors++;
               $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                        e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
            end else begin
               $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
            end
         end
      end
   endtask

   task automatic test_reset_midcount();
      sb_t  e;
      obs_t o;
      for (int s = 0; s < 3; s++) begin
         if (s == 0) begin
            load = 1'b1; load_val = 4'd5; en = 1'b0; reset = 1'b0;
            push(I_WRAP, 4'd5, 4'b0111, 1'b0, 1'b0, "mid_load5");
         end else if (s == 1) begin
            load = 1'b0; en = 1'b1; step = 3'd3; reset = 1'b1;
            push(I_WRAP, 4'd0, 4'b0000, 1'b0, 1'b1, "mid_reset");
         end else begin
            reset = 1'b0; en = 1'b1; step = 3'd1;
            push(I_WRAP, 4'd1, 4'b0001, 1'b0, 1'b0, "after_reset");
         end
         tick();
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.inst);
            checks++;
            if (o !== e.exp) begin
               errors++;
               $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                        e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
            end else begin
               $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
            end
         end
      end
   endtask

   task automatic test_gray_walk();
      sb_t          e;
      obs_t         o;
      logic [N-1:0] exp_bin, nb, prev_gray;
      load = 1'b1; load_val = 4'd13; en = 1'b0;
      exp_bin = 4'd13;
      push(I_NZ, exp_bin, gray_of(exp_bin), 1'b0, 1'b0, "walk_load");
      for (int k = 0; k <= 40; k++) begin
         if (k > 0) begin
            load = 1'b0; en = 1'b1; step = 3'd1;
            nb = exp_bin + 4'd1;
            push(I_NZ, nb, gray_of(nb), exp_bin == 4'd15, nb == 4'd0, "walk");
            exp_bin = nb;
         end
         tick();
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = observe(e.inst);
            checks++;
            if (o !== e.exp) begin
               errors++;
               $display("FAIL %s inst=%0d got bin=%0d gray=%b ovf=%b zero=%b need bin=%0d gray=%b ovf=%b zero=%b",
                        e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero, e.exp.bin, e.exp.gray, e.exp.ovf, e.exp.zero);
            end else begin
               $display("txn %s inst=%0d bin=%0d gray=%b ovf=%b zero=%b ok", e.tag, e.inst, o.bin, o.gray, o.ovf, o.zero);
            end
         end
         if (k > 0) begin
            checks++;
            if ($countones(prev_gray ^ h_gray) != 1) begin
               errors++;
               $display("FAIL gray_hamming step=%0d got distance=%0d (%b -> %b) need distance=1",
                        k, $countones(prev_gray ^ h_gray), prev_gray, h_gray);
            end
         end
         prev_gray = h_gray;
      end
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; load = 1'b0; load_val = '0; step = '0;
      test_reset();
      test_legacy_down();
      test_wrap();
      test_saturate();
      test_load_priority();
      test_reset_midcount();
      test_gray_walk();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
